// File: rtl/panda_pkg.sv
// Shared types and constants for the Panda single-cycle core.
package panda_pkg;

  typedef enum logic [2:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_VALID,
    FETCH_ERROR
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/panda_next_pc.sv
// Next-PC selection for the fetch stage: sequential, jump or taken branch.
module panda_next_pc (
  input  logic [31:0] pc,
  input  logic        jump,
  input  logic        branch,
  input  logic        cond,
  input  logic [31:0] target,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic taken;

  always_comb begin
    taken = jump | (branch & cond);
    if (taken) begin
      // JALR clears bit 0 of the target; bit 1 is left for the alignment check.
      next_pc = {target[31:1], 1'b0};
    end else begin
      next_pc = pc + 32'd4;
    end
    misaligned = next_pc[1];
  end

endmodule

// File: rtl/panda_sc_fetch.sv
// Panda single-cycle fetch stage: PC register, req/gnt/rvalid fetch FSM, retire counter.
module panda_sc_fetch
  import panda_pkg::*;
#(
  parameter logic [31:0] BootAddr = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_next_o,
  input  logic        jump_i,
  input  logic        branch_i,
  input  logic        branch_cond_i,
  input  logic [31:0] jump_target_i,
  output logic        fetch_err_o,
  output logic [31:0] instr_count_o
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  count_q;
  logic         err_q;

  logic [31:0]  next_pc;
  logic         misaligned;

  panda_next_pc u_next_pc (
    .pc         (pc_q),
    .jump       (jump_i),
    .branch     (branch_i),
    .cond       (branch_cond_i),
    .target     (jump_target_i),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FETCH_IDLE;
      pc_q    <= BootAddr;
      instr_q <= NOP_INSTR;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        FETCH_IDLE: state_q <= FETCH_REQ;
        FETCH_REQ: begin
          if (instr_gnt_i) state_q <= FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (instr_rvalid_i) begin
            instr_q <= instr_rdata_i;
            state_q <= FETCH_VALID;
          end
        end
        FETCH_VALID: begin
          if (instr_ready_i) begin
            // A misaligned target freezes PC and count so the faulting instruction stays visible.
            if (misaligned) begin
              err_q   <= 1'b1;
              state_q <= FETCH_ERROR;
            end else begin
              pc_q    <= next_pc;
              count_q <= count_q + 32'd1;
              state_q <= FETCH_REQ;
            end
          end
        end
        FETCH_ERROR: state_q <= FETCH_ERROR;
        default:     state_q <= FETCH_IDLE;
      endcase
    end
  end

  assign instr_req_o   = (state_q == FETCH_REQ);
  assign instr_valid_o = (state_q == FETCH_VALID);
  assign instr_addr_o  = pc_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign pc_next_o     = pc_q + 32'd4;
  assign fetch_err_o   = err_q;
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_panda_sc_fetch.sv
// Directed bench for panda_sc_fetch: vector table of retires plus stall/error/reset sequences.
module tb_panda_sc_fetch;
  import panda_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_addr_o;
  logic [31:0] instr_rdata_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] pc_o;
  logic [31:0] pc_next_o;
  logic        jump_i;
  logic        branch_i;
  logic        branch_cond_i;
  logic [31:0] jump_target_i;
  logic        fetch_err_o;
  logic [31:0] instr_count_o;

  always #5 clk = ~clk;

  panda_sc_fetch #(.BootAddr(32'h0000_0100)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rdata_i  (instr_rdata_i),
    .instr_o        (instr_o),
    .instr_valid_o  (instr_valid_o),
    .instr_ready_i  (instr_ready_i),
    .pc_o           (pc_o),
    .pc_next_o      (pc_next_o),
    .jump_i         (jump_i),
    .branch_i       (branch_i),
    .branch_cond_i  (branch_cond_i),
    .jump_target_i  (jump_target_i),
    .fetch_err_o    (fetch_err_o),
    .instr_count_o  (instr_count_o)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  typedef struct {
    logic [31:0] exp_addr;
    logic [31:0] rdata;
    logic        jump;
    logic        branch;
    logic        cond;
    logic [31:0] target;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Serve one fetch: bounded wait for req, optional gnt/rvalid stalls, then check the VALID outputs.
  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] rdata,
                          input int gnt_dly, input int rv_dly);
    int n = 0;
    while (!instr_req_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'd0, instr_req_o}, 32'd1);
    check("fetch_addr", instr_addr_o, exp_addr);
    for (int i = 0; i < gnt_dly; i++) begin
      @(negedge clk);
      check("req_hold", {31'd0, instr_req_o}, 32'd1);
      check("addr_hold", instr_addr_o, exp_addr);
    end
    instr_gnt_i = 1'b1;
    @(negedge clk);
    instr_gnt_i = 1'b0;
    check("req_drop", {31'd0, instr_req_o}, 32'd0);
    for (int i = 0; i < rv_dly; i++) begin
      @(negedge clk);
      check("valid_low_wait", {31'd0, instr_valid_o}, 32'd0);
    end
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = rdata;
    @(negedge clk);
    instr_rvalid_i = 1'b0;
    check("valid", {31'd0, instr_valid_o}, 32'd1);
    check("instr", instr_o, rdata);
    check("pc", pc_o, exp_addr);
    check("pc_next", pc_next_o, exp_addr + 32'd4);
  endtask

  task automatic retire(input logic j, input logic b, input logic c, input logic [31:0] t);
    instr_ready_i = 1'b1;
    jump_i        = j;
    branch_i      = b;
    branch_cond_i = c;
    jump_target_i = t;
    @(negedge clk);
    instr_ready_i = 1'b0;
    jump_i        = 1'b0;
    branch_i      = 1'b0;
    branch_cond_i = 1'b0;
    jump_target_i = '0;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0104, 32'h1111_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0000}; // sequential
    vecs[1] = '{32'h0000_0108, 32'h1111_0002, 1'b0, 1'b1, 1'b1, 32'h0000_0040}; // branch taken
    vecs[2] = '{32'h0000_0040, 32'h1111_0003, 1'b0, 1'b1, 1'b0, 32'h0000_0080}; // branch not taken
    vecs[3] = '{32'h0000_0044, 32'h1111_0004, 1'b1, 1'b0, 1'b0, 32'h0000_0201}; // jump, bit0 cleared
    vecs[4] = '{32'h0000_0200, 32'h1111_0005, 1'b0, 1'b0, 1'b1, 32'h0000_0500}; // cond without branch
    vecs[5] = '{32'h0000_0204, 32'h1111_0006, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC}; // jump over branch
    vecs[6] = '{32'hFFFF_FFFC, 32'h1111_0007, 1'b0, 1'b0, 1'b0, 32'h0000_0000}; // wraps to 0

    rst_ni = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
    instr_ready_i = 1'b0; jump_i = 1'b0; branch_i = 1'b0; branch_cond_i = 1'b0;
    jump_target_i = '0;
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, instr_req_o}, 32'd0);
    check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    check("rst_pc", pc_o, 32'h100);
    check("rst_instr", instr_o, NOP_INSTR);
    check("rst_count", instr_count_o, 32'd0);
    check("rst_err", {31'd0, fetch_err_o}, 32'd0);

    // Release: cycle 1 IDLE, cycle 2 REQ, cycle 3 WAIT, cycle 4 VALID.
    rst_ni = 1'b1;
    check("c1_req", {31'd0, instr_req_o}, 32'd0);
    @(negedge clk);
    check("c2_req", {31'd0, instr_req_o}, 32'd1);
    check("c2_addr", instr_addr_o, 32'h100);
    instr_gnt_i = 1'b1;
    @(negedge clk);
    instr_gnt_i = 1'b0;
    check("c3_valid", {31'd0, instr_valid_o}, 32'd0);
    instr_rvalid_i = 1'b1; instr_rdata_i = 32'hABCD_0000;
    @(negedge clk);
    instr_rvalid_i = 1'b0;
    check("c4_valid", {31'd0, instr_valid_o}, 32'd1);
    check("c4_instr", instr_o, 32'hABCD_0000);
    check("c4_pc_next", pc_next_o, 32'h104);
    retire(1'b0, 1'b0, 1'b0, '0);
    check("count_1", instr_count_o, 32'd1);

    for (int i = 0; i < 7; i++) begin
      do_fetch(vecs[i].exp_addr, vecs[i].rdata, 0, 0);
      retire(vecs[i].jump, vecs[i].branch, vecs[i].cond, vecs[i].target);
      check("count_vec", instr_count_o, 32'(i + 2));
      check("err_vec", {31'd0, fetch_err_o}, 32'd0);
    end

    // Stalled fetch at the wrapped PC, then ready held low with a misaligned jump driven.
    do_fetch(32'h0000_0000, 32'hCAFE_0008, 3, 5);
    for (int i = 0; i < 4; i++) begin
      jump_i = 1'b1; jump_target_i = 32'h42;
      @(negedge clk);
      check("hold_valid", {31'd0, instr_valid_o}, 32'd1);
      check("hold_pc", pc_o, 32'h0);
      check("hold_instr", instr_o, 32'hCAFE_0008);
    end
    retire(1'b1, 1'b0, 1'b0, 32'h42);
    check("err_set", {31'd0, fetch_err_o}, 32'd1);
    check("err_req", {31'd0, instr_req_o}, 32'd0);
    check("err_valid", {31'd0, instr_valid_o}, 32'd0);
    check("err_count", instr_count_o, 32'd8);
    check("err_pc", pc_o, 32'h0);
    for (int i = 0; i < 3; i++) begin
      instr_gnt_i = 1'b1; instr_rvalid_i = 1'b1;
      @(negedge clk);
      check("err_stuck", {31'd0, fetch_err_o}, 32'd1);
      check("err_req_low", {31'd0, instr_req_o}, 32'd0);
    end
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;

    rst_ni = 1'b0;
    #1;
    check("rst2_err", {31'd0, fetch_err_o}, 32'd0);
    check("rst2_count", instr_count_o, 32'd0);
    check("rst2_pc", pc_o, 32'h100);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("rst2_req", {31'd0, instr_req_o}, 32'd1);
    check("rst2_addr", instr_addr_o, 32'h100);
    #2 rst_ni = 1'b0;
    #1 check("async_req_drop", {31'd0, instr_req_o}, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    instr_gnt_i = 1'b1;
    @(negedge clk);
    instr_gnt_i = 1'b0;
    rst_ni = 1'b0;
    #1 check("wait_rst_state", {29'd0, dut.state_q}, {29'd0, FETCH_IDLE});
    @(negedge clk);
    rst_ni = 1'b1;
    instr_rvalid_i = 1'b1; instr_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    instr_rvalid_i = 1'b0;
    check("late_rvalid_valid", {31'd0, instr_valid_o}, 32'd0);
    check("late_rvalid_instr", instr_o, NOP_INSTR);
    do_fetch(32'h100, 32'h1357_9BDF, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
